dmem_access_arbiter: RTL and testbench
======================================

// Module: dmem_access_arbiter
// PURPOSE
//  Shares the single data memory between two requesters: the MEM pipeline stage (port P) and the
//  OS-initiated cache-switch engine (port S, context save/restore traffic). Sequences each access
//  with an IDLE/ISSUE/WAIT/DONE FSM and returns per-port busywait, so the MEM stage and its
//  pipeline register stall while the memory is owned by the switch engine.
// PARAMETERS
//  ADDR_W        32  address width, both ports and memory side
//  DATA_W        32  data width
//  STARVE_LIMIT   8  consecutive P wins while S waits before S is forced to win (1..2^CNT_W-1)
//  CNT_W          4  starvation counter width
// PORTS
//  clk           in   1       clock, all state on rising edge
//  reset         in   1       asynchronous, active-low reset (0 = reset)
//  p_read/p_write in  1       pipeline read/write request (never both)
//  p_addr        in   ADDR_W  pipeline address
//  p_wdata       in   DATA_W  pipeline store data
//  p_rdata       out  DATA_W  pipeline load data
//  p_busywait    out  1       pipeline stall
//  s_read/s_write in  1       switch-engine read/write request
//  s_addr/s_wdata in  ADDR_W/DATA_W  switch-engine address / store data
//  s_rdata       out  DATA_W  switch-engine load data
//  s_busywait    out  1       switch-engine stall
//  mem_read/mem_write out 1   memory request strobes
//  mem_addr/mem_wdata out ADDR_W/DATA_W  memory address / store data
//  mem_rdata     in   DATA_W  memory read data, valid when mem_busywait falls
//  mem_busywait  in   1       memory busy; rises the edge after a strobe, falls when done
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, owner=P, starve_cnt=0; mem_read/mem_write=0, mem_addr=0,
//   mem_wdata=0, p_rdata=0, s_rdata=0. busywait outputs follow the combinational rule below.
//  Requester protocol: hold read/write/addr/wdata stable until own busywait is low at a clock edge.
//  x_busywait = (x_read|x_write) & ~(state==DONE & owner==x). Combinational; 0 when idle.
//  IDLE: no request -> stay. Otherwise pick winner, register owner, addr, wdata, dir -> ISSUE.
//   Winner: P if only P; S if only S; both -> P unless starve_cnt==STARVE_LIMIT, then S.
//  starve_cnt: +1 on each P win while S requests; cleared on S win; saturates, never wraps.
//  ISSUE (1 cycle): mem_read/mem_write = registered dir, mem_addr/mem_wdata = latched values -> WAIT.
//  WAIT: strobes and addr held; mem_busywait=0 at edge -> latch mem_rdata into owner's x_rdata
//   (reads only; writes leave x_rdata unchanged), drop strobes -> DONE.
//  DONE (1 cycle): owner's busywait=0; non-owner stays stalled -> IDLE. Back-to-back access
//   therefore costs 3 cycles + memory latency; owner sees new request only after returning to IDLE.
//  x_rdata holds last read value until the next read completes for that port.
//  Requester drops request mid-access: transaction still completes on memory; result is stored,
//   no error flagged. Request asserted in DONE by owner is treated as a new access in IDLE.
//  Both p_read & p_write high: treated as write (protocol error, no other effect).
//  Reset mid-access: strobes drop immediately; memory side is responsible for abandoning access.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds out ports stat_p_grants[31:0], stat_s_grants[31:0],
//   stat_p_stall[31:0]: grant counts (+1 on IDLE->ISSUE per winner) and cycles with p_busywait=1
//   while owner==S or state==IDLE with S winning; all wrap at 2^32, clear on reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 P read 0x40 only, memory latency 2 -> ISSUE next cycle, p_busywait low exactly in DONE,
//    p_rdata=memory word 0x40; s_busywait stays 0.
//  2 P and S request together, starve_cnt=0 -> P granted first; S granted next IDLE; S stalled
//    through P's DONE; starve_cnt=1 after P, 0 after S.
//  3 P requests continuously, S holds read 0x100 -> S wins on 9th arbitration (STARVE_LIMIT=8).
//  4 S write 0xDEADBEEF to 0x80 then P read 0x80 -> p_rdata=0xDEADBEEF, s_rdata unchanged.
//  5 reset=0 while in WAIT -> mem_read/mem_write 0 same cycle, state IDLE, rdata ports 0.
//  6 DMEM_ARB_STATS_EN: 3 P + 2 S accesses -> stat_p_grants=3, stat_s_grants=2; undefined:
//    build succeeds without stat ports.

Source files
------------

// File: rtl/dmem_access_arbiter_if.sv
// Bundles the pipeline (P), switch-engine (S) and data-memory buses.
// Latency: none, wires only.
// Backpressure: carried by the p_/s_/mem_ busywait signals.
interface dmem_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Pipeline (MEM stage) port
    logic              p_read;
    logic              p_write;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_busywait;

    // Cache-switch engine port
    logic              s_read;
    logic              s_write;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_busywait;

    // Data-memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_busywait;

    // Arbiter view: serves both requesters and drives the memory bus.
    modport master (
        input  p_read, p_write, p_addr, p_wdata,
        output p_rdata, p_busywait,
        input  s_read, s_write, s_addr, s_wdata,
        output s_rdata, s_busywait,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_busywait
    );

    // Environment view: the two requesters plus the memory itself.
    modport slave (
        output p_read, p_write, p_addr, p_wdata,
        input  p_rdata, p_busywait,
        output s_read, s_write, s_addr, s_wdata,
        input  s_rdata, s_busywait,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_busywait
    );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Shares one data memory between the MEM stage (P) and the cache-switch engine (S); optional stats via DMEM_ARB_STATS_EN.
// Latency: 3 cycles (IDLE->ISSUE->WAIT->DONE) plus memory busywait time per access.
// Backpressure: x_busywait stalls each requester until DONE of its own access; S forced through after STARVE_LIMIT P wins.
module dmem_access_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_access_arbiter_if.master bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_p_grants,
    output logic [31:0]           stat_s_grants,
    output logic [31:0]           stat_p_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic             OWN_P   = 1'b0;
    localparam logic             OWN_S   = 1'b1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q;
    logic                owner_q;
    logic [CNT_W-1:0]    starve_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   p_rdata_q;
    logic [DATA_W-1:0]   s_rdata_q;

    logic                p_req;
    logic                s_req;
    logic                any_req;
    logic                win_s_d;
    logic [CNT_W-1:0]    starve_d;
    logic                sel_read_d;
    logic                sel_write_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;

    // Arbitration and starvation bookkeeping for the next IDLE decision.
    always_comb begin
        p_req   = bus.p_read | bus.p_write;
        s_req   = bus.s_read | bus.s_write;
        any_req = p_req | s_req;
        // S wins when alone, or when P has starved it for LIMIT grants.
        win_s_d = s_req & (~p_req | (starve_q == LIMIT));

        starve_d = starve_q;
        if (win_s_d) begin
            starve_d = '0;
        end else if (s_req && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        // Read and write together is a protocol error: the write takes precedence.
        if (win_s_d) begin
            sel_write_d = bus.s_write;
            sel_read_d  = bus.s_read & ~bus.s_write;
            sel_addr_d  = bus.s_addr;
            sel_wdata_d = bus.s_wdata;
        end else begin
            sel_write_d = bus.p_write;
            sel_read_d  = bus.p_read & ~bus.p_write;
            sel_addr_d  = bus.p_addr;
            sel_wdata_d = bus.p_wdata;
        end
    end

    // Access sequencer: latch the winner in IDLE, strobe in ISSUE, wait out memory, release in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_P;
            starve_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p_rdata_q   <= '0;
            s_rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q     <= win_s_d;
                        starve_q    <= starve_d;
                        // Strobes are registered here so they are visible throughout ISSUE.
                        mem_read_q  <= sel_read_d;
                        mem_write_q <= sel_write_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!bus.mem_busywait) begin
                        // Result is kept even if the requester already dropped its request.
                        if (mem_read_q) begin
                            if (owner_q == OWN_S) begin
                                s_rdata_q <= bus.mem_rdata;
                            end else begin
                                p_rdata_q <= bus.mem_rdata;
                            end
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A requester is released only in the DONE cycle of its own access.
    assign bus.p_busywait = p_req & ~((state_q == ST_DONE) & (owner_q == OWN_P));
    assign bus.s_busywait = s_req & ~((state_q == ST_DONE) & (owner_q == OWN_S));

    assign bus.p_rdata   = p_rdata_q;
    assign bus.s_rdata   = s_rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_p_grants_q;
    logic [31:0] stat_s_grants_q;
    logic [31:0] stat_p_stall_q;
    logic        p_stalled_by_s;

    // P is charged a stall cycle only when S holds or is just taking the memory.
    assign p_stalled_by_s = bus.p_busywait &
                            (((state_q != ST_IDLE) & (owner_q == OWN_S)) |
                             ((state_q == ST_IDLE) & win_s_d));

    // Free-running grant and stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_p_grants_q <= '0;
            stat_s_grants_q <= '0;
            stat_p_stall_q  <= '0;
        end else begin
            if ((state_q == ST_IDLE) && any_req) begin
                if (win_s_d) begin
                    stat_s_grants_q <= stat_s_grants_q + 32'd1;
                end else begin
                    stat_p_grants_q <= stat_p_grants_q + 32'd1;
                end
            end
            if (p_stalled_by_s) begin
                stat_p_stall_q <= stat_p_stall_q + 32'd1;
            end
        end
    end

    assign stat_p_grants = stat_p_grants_q;
    assign stat_s_grants = stat_s_grants_q;
    assign stat_p_stall  = stat_p_stall_q;
`endif

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a 2-cycle busywait memory model.
// Latency: checks the IDLE/ISSUE/WAIT/DONE timing of a single access cycle by cycle.
// Backpressure: drivers hold each request until their own busywait is low at an edge.
module tb_dmem_access_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MEM_LAT = 2;
    localparam int TMO     = 300;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dmem_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_p_grants;
    logic [31:0] stat_s_grants;
    logic [31:0] stat_p_stall;
`endif

    dmem_access_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(8),
        .CNT_W       (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_p_grants(stat_p_grants),
        .stat_s_grants(stat_s_grants),
        .stat_p_stall (stat_p_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected rdata per port, and optional expected grant order (0=P, 1=S).
    logic [31:0] p_q[$];
    logic [31:0] s_q[$];
    logic [31:0] ord_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory model: word array, busywait rises the edge after a strobe, high MEM_LAT cycles.
    logic [31:0] mem [0:255];
    int          mem_cnt;
    logic        mem_ack;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem_cnt          <= 0;
            mem_ack          <= 1'b0;
            bus.mem_busywait <= 1'b0;
            bus.mem_rdata    <= '0;
        end else if (mem_cnt > 0) begin
            if (mem_cnt == 1) begin
                bus.mem_busywait <= 1'b0;
                mem_ack          <= 1'b1;
                if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
                else               bus.mem_rdata <= mem[bus.mem_addr[9:2]];
            end
            mem_cnt <= mem_cnt - 1;
        end else if ((bus.mem_read || bus.mem_write) && !mem_ack) begin
            bus.mem_busywait <= 1'b1;
            mem_cnt          <= MEM_LAT;
        end else if (!(bus.mem_read || bus.mem_write)) begin
            mem_ack <= 1'b0;
        end
    end

    // Monitor: a completion is a requesting port whose busywait is low mid-cycle.
    always @(negedge clk) begin : mon
        logic pd;
        logic sd;
        if (reset) begin
            pd = (bus.p_read | bus.p_write) & ~bus.p_busywait;
            sd = (bus.s_read | bus.s_write) & ~bus.s_busywait;
            if (pd) begin
                if (p_q.size() == 0) fail_now("p_unexpected_completion");
                else check("p_rdata", bus.p_rdata, p_q.pop_front());
                if (ord_q.size() != 0) check("grant_order", 32'd0, ord_q.pop_front());
                if (bus.s_read | bus.s_write) check("s_stalled_in_p_done", 32'(bus.s_busywait), 32'd1);
            end
            if (sd) begin
                if (s_q.size() == 0) fail_now("s_unexpected_completion");
                else check("s_rdata", bus.s_rdata, s_q.pop_front());
                if (ord_q.size() != 0) check("grant_order", 32'd1, ord_q.pop_front());
                if (bus.p_read | bus.p_write) check("p_stalled_in_s_done", 32'(bus.p_busywait), 32'd1);
            end
        end
    end

    task automatic p_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp);
        bit ok = 1'b0;
        p_q.push_back(exp);
        bus.p_read  = ~wr;
        bus.p_write = wr;
        bus.p_addr  = addr;
        bus.p_wdata = wdata;
        for (int n = 0; n < TMO && !ok; n++) begin
            @(negedge clk);
            if (!bus.p_busywait) ok = 1'b1;
        end
        if (!ok) fail_now("p_access_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic s_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp);
        bit ok = 1'b0;
        s_q.push_back(exp);
        bus.s_read  = ~wr;
        bus.s_write = wr;
        bus.s_addr  = addr;
        bus.s_wdata = wdata;
        for (int n = 0; n < TMO && !ok; n++) begin
            @(negedge clk);
            if (!bus.s_busywait) ok = 1'b1;
        end
        if (!ok) fail_now("s_access_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic p_idle();
        bus.p_read  = 1'b0;
        bus.p_write = 1'b0;
    endtask

    task automatic s_idle();
        bus.s_read  = 1'b0;
        bus.s_write = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_watchdog at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.p_read = 1'b0; bus.p_write = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.s_read = 1'b0; bus.s_write = 1'b0; bus.s_addr = '0; bus.s_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_read",   32'(bus.mem_read),   32'd0);
        check("rst_mem_write",  32'(bus.mem_write),  32'd0);
        check("rst_mem_addr",   bus.mem_addr,        32'd0);
        check("rst_mem_wdata",  bus.mem_wdata,       32'd0);
        check("rst_p_rdata",    bus.p_rdata,         32'd0);
        check("rst_s_rdata",    bus.s_rdata,         32'd0);
        check("rst_p_busywait", 32'(bus.p_busywait), 32'd0);
        check("rst_s_busywait", 32'(bus.s_busywait), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: lone P read of 0x40, cycle-by-cycle timing
        p_q.push_back(32'hA000_0010);
        bus.p_read = 1'b1;
        bus.p_addr = 32'h40;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("t1_p_busywait_c%0d", k), 32'(bus.p_busywait), (k == 5) ? 32'd0 : 32'd1);
            check($sformatf("t1_s_busywait_c%0d", k), 32'(bus.s_busywait), 32'd0);
            if (k == 0) check("t1_no_strobe_idle", 32'(bus.mem_read), 32'd0);
            if (k == 1) begin
                check("t1_issue_strobe", 32'(bus.mem_read), 32'd1);
                check("t1_issue_addr",   bus.mem_addr,      32'h40);
            end
            if (k == 5) check("t1_done_strobe_dropped", 32'(bus.mem_read), 32'd0);
        end
        @(posedge clk);
        #1;
        p_idle();

        // 2: simultaneous P and S, P first
        ord_q.push_back(32'd0);
        ord_q.push_back(32'd1);
        fork
            begin p_access(1'b0, 32'h44, 32'h0, 32'hA000_0011); p_idle(); end
            begin s_access(1'b0, 32'h48, 32'h0, 32'hA000_0012); s_idle(); end
        join

        // 3: continuous P against a waiting S read; S wins the 9th arbitration
        for (int i = 0; i < 8; i++) ord_q.push_back(32'd0);
        ord_q.push_back(32'd1);
        ord_q.push_back(32'd0);
        ord_q.push_back(32'd0);
        fork
            begin
                for (int i = 0; i < 10; i++)
                    p_access(1'b0, 32'h40 + 32'(4 * i), 32'h0, 32'hA000_0010 + 32'(i));
                p_idle();
            end
            begin s_access(1'b0, 32'h100, 32'h0, 32'hA000_0040); s_idle(); end
        join

        // 4: S write then P read of the same word; S rdata untouched by the write
        s_access(1'b1, 32'h80, 32'hDEAD_BEEF, 32'hA000_0040);
        s_idle();
        p_access(1'b0, 32'h80, 32'h0,         32'hDEAD_BEEF);
        p_access(1'b1, 32'h84, 32'h1234_5678, 32'hDEAD_BEEF);
        p_access(1'b0, 32'h84, 32'h0,         32'h1234_5678);
        p_idle();

        // 5: reset while the memory access is in WAIT
        bus.p_read = 1'b1;
        bus.p_addr = 32'hC0;
        repeat (3) @(negedge clk);
        check("t5_wait_strobe", 32'(bus.mem_read), 32'd1);
        #1;
        reset = 1'b0;
        bus.p_read = 1'b0;
        #1;
        check("t5_mem_read",  32'(bus.mem_read),  32'd0);
        check("t5_mem_write", 32'(bus.mem_write), 32'd0);
        check("t5_mem_addr",  bus.mem_addr,       32'd0);
        check("t5_p_rdata",   bus.p_rdata,        32'd0);
        check("t5_s_rdata",   bus.s_rdata,        32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_p_busywait_idle", 32'(bus.p_busywait), 32'd0);
        @(posedge clk);
        #1;

        // 6: 3 P + 2 S accesses after reset
        p_access(1'b0, 32'hC0,  32'h0,         32'hA000_0030); p_idle();
        s_access(1'b0, 32'h104, 32'h0,         32'hA000_0041); s_idle();
        p_access(1'b0, 32'hC4,  32'h0,         32'hA000_0031); p_idle();
        s_access(1'b1, 32'h108, 32'h55AA_55AA, 32'hA000_0041); s_idle();
        p_access(1'b0, 32'h108, 32'h0,         32'h55AA_55AA); p_idle();
`ifdef DMEM_ARB_STATS_EN
        check("t6_stat_p_grants", stat_p_grants, 32'd3);
        check("t6_stat_s_grants", stat_s_grants, 32'd2);
        check("t6_stat_p_stall",  stat_p_stall,  32'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("end_p_queue_empty",   32'(p_q.size()),   32'd0);
        check("end_s_queue_empty",   32'(s_q.size()),   32'd0);
        check("end_ord_queue_empty", 32'(ord_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
